// File: rtl/fp_addsub_post_norm.sv
// Single-precision add/sub back end: 27-bit add/subtract, leading-zero normalize,
// round-to-nearest-even and IEEE-754 packing in a fixed 3-stage pipeline.
module fp_addsub_post_norm (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [26:0] fracta_in,
  input  logic [26:0] fractb_in,
  input  logic [7:0]  exp_in,
  input  logic        sign_in,
  input  logic        fasu_op_in,
  output logic        out_valid,
  output logic [31:0] result,
  output logic        out_overflow,
  output logic        out_zero,
  output logic        out_inexact
);

  logic [27:0] s1_sum_d, s1_sum_q;
  logic [7:0]  s1_exp_d, s1_exp_q;
  logic        s1_sign_d, s1_sign_q;
  logic        s1_inf_d, s1_inf_q;
  logic        s1_valid_d, s1_valid_q;

  logic [26:0] s2_frac_d, s2_frac_q;
  logic [8:0]  s2_exp_d, s2_exp_q;
  logic        s2_sign_d, s2_sign_q;
  logic        s2_inf_d, s2_inf_q;
  logic        s2_zero_d, s2_zero_q;
  logic        s2_valid_d, s2_valid_q;

  logic [31:0] result_d, result_q;
  logic        out_overflow_d, out_overflow_q;
  logic        out_zero_d, out_zero_q;
  logic        out_inexact_d, out_inexact_q;
  logic        out_valid_d, out_valid_q;

  logic [8:0]  eff_exp;
  logic [4:0]  lz;

  logic        lsb_bit, guard_bit, round_bit, sticky_bit, round_up;
  logic [24:0] mant_sum;
  logic [22:0] mant;
  logic [8:0]  fin_exp;

  always_comb begin
    s1_sum_d   = fasu_op_in ? ({1'b0, fracta_in} + {1'b0, fractb_in})
                            : ({1'b0, fracta_in} - {1'b0, fractb_in});
    s1_exp_d   = exp_in;
    s1_sign_d  = sign_in;
    s1_inf_d   = (exp_in == 8'hFF);
    s1_valid_d = in_valid;
  end

  // Denormals are treated as living at exponent 1, so normalization may only
  // shift left until the exponent bottoms out there.
  always_comb begin
    eff_exp = (s1_exp_q == 8'd0) ? 9'd1 : {1'b0, s1_exp_q};
    lz      = 5'd27;
    for (int i = 0; i < 27; i++) begin
      if (s1_sum_q[i]) lz = 5'(26 - i);
    end

    s2_frac_d  = s1_sum_q[26:0];
    s2_exp_d   = eff_exp;
    s2_zero_d  = 1'b0;
    s2_sign_d  = s1_sign_q;
    s2_inf_d   = s1_inf_q;
    s2_valid_d = s1_valid_q;

    if (s1_sum_q[27]) begin
      s2_frac_d = {s1_sum_q[27:2], s1_sum_q[1] | s1_sum_q[0]};
      s2_exp_d  = eff_exp + 9'd1;
    end else if (s1_sum_q[26:0] == 27'd0) begin
      s2_frac_d = 27'd0;
      s2_exp_d  = 9'd0;
      s2_zero_d = 1'b1;
    end else if ({4'd0, lz} < eff_exp) begin
      s2_frac_d = s1_sum_q[26:0] << lz;
      s2_exp_d  = eff_exp - {4'd0, lz};
    end else begin
      s2_frac_d = s1_sum_q[26:0] << (eff_exp - 9'd1);
      s2_exp_d  = 9'd0;
    end
  end

  always_comb begin
    lsb_bit    = s2_frac_q[3];
    guard_bit  = s2_frac_q[2];
    round_bit  = s2_frac_q[1];
    sticky_bit = s2_frac_q[0];
    round_up   = guard_bit & (round_bit | sticky_bit | lsb_bit);
    mant_sum   = {1'b0, s2_frac_q[26:3]} + {24'd0, round_up};
    mant       = mant_sum[24] ? mant_sum[23:1] : mant_sum[22:0];
    fin_exp    = s2_exp_q + {8'd0, mant_sum[24]};
    // A denormal whose rounding reaches the hidden bit becomes the smallest normal.
    if ((s2_exp_q == 9'd0) && mant_sum[23]) fin_exp = 9'd1;

    result_d       = result_q;
    out_overflow_d = out_overflow_q;
    out_zero_d     = out_zero_q;
    out_inexact_d  = out_inexact_q;
    out_valid_d    = s2_valid_q;

    if (s2_valid_q) begin
      out_overflow_d = 1'b0;
      out_zero_d     = 1'b0;
      out_inexact_d  = (guard_bit | round_bit | sticky_bit) & ~s2_inf_q;
      if (s2_inf_q || (fin_exp >= 9'h0FF)) begin
        result_d       = {s2_sign_q, 8'hFF, 23'd0};
        out_overflow_d = ~s2_inf_q;
      end else if (s2_zero_q) begin
        result_d   = {s2_sign_q, 31'd0};
        out_zero_d = 1'b1;
      end else begin
        result_d = {s2_sign_q, fin_exp[7:0], mant};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_sum_q       <= '0;
      s1_exp_q       <= '0;
      s1_sign_q      <= 1'b0;
      s1_inf_q       <= 1'b0;
      s1_valid_q     <= 1'b0;
      s2_frac_q      <= '0;
      s2_exp_q       <= '0;
      s2_sign_q      <= 1'b0;
      s2_inf_q       <= 1'b0;
      s2_zero_q      <= 1'b0;
      s2_valid_q     <= 1'b0;
      result_q       <= '0;
      out_overflow_q <= 1'b0;
      out_zero_q     <= 1'b0;
      out_inexact_q  <= 1'b0;
      out_valid_q    <= 1'b0;
    end else begin
      s1_sum_q       <= s1_sum_d;
      s1_exp_q       <= s1_exp_d;
      s1_sign_q      <= s1_sign_d;
      s1_inf_q       <= s1_inf_d;
      s1_valid_q     <= s1_valid_d;
      s2_frac_q      <= s2_frac_d;
      s2_exp_q       <= s2_exp_d;
      s2_sign_q      <= s2_sign_d;
      s2_inf_q       <= s2_inf_d;
      s2_zero_q      <= s2_zero_d;
      s2_valid_q     <= s2_valid_d;
      result_q       <= result_d;
      out_overflow_q <= out_overflow_d;
      out_zero_q     <= out_zero_d;
      out_inexact_q  <= out_inexact_d;
      out_valid_q    <= out_valid_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign result       = result_q;
  assign out_overflow = out_overflow_q;
  assign out_zero     = out_zero_q;
  assign out_inexact  = out_inexact_q;

endmodule

// File: tb/tb_fp_addsub_post_norm.sv
// Scoreboard bench for fp_addsub_post_norm: expected results are queued when a
// vector is driven and compared, in order, against what the DUT emits.
module tb_fp_addsub_post_norm;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [26:0] fracta_in;
  logic [26:0] fractb_in;
  logic [7:0]  exp_in;
  logic        sign_in;
  logic        fasu_op_in;
  logic        out_valid;
  logic [31:0] result;
  logic        out_overflow;
  logic        out_zero;
  logic        out_inexact;

  typedef struct {
    logic [26:0] a;
    logic [26:0] b;
    logic [7:0]  e;
    logic        s;
    logic        op;
    logic [31:0] res;
    logic [2:0]  flg;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic [2:0]  flg;
    int          cyc;
  } rec_t;

  vec_t vt [16];
  rec_t expq [$];
  rec_t obsq [$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  fp_addsub_post_norm dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .fracta_in    (fracta_in),
    .fractb_in    (fractb_in),
    .exp_in       (exp_in),
    .sign_in      (sign_in),
    .fasu_op_in   (fasu_op_in),
    .out_valid    (out_valid),
    .result       (result),
    .out_overflow (out_overflow),
    .out_zero     (out_zero),
    .out_inexact  (out_inexact)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Outputs are sampled on the falling edge, well away from the launching edge.
  always @(negedge clk) begin
    if (out_valid) obsq.push_back('{result, {out_overflow, out_zero, out_inexact}, cyc});
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, bad=%0d", bad);
    $fatal(1, "[TB] watchdog expired");
  end

  // Flags are packed {overflow, zero, inexact}.
  initial begin
    vt[0]  = '{27'h4000000, 27'h4000000, 8'h7F, 1'b0, 1'b1, 32'h40000000, 3'b000};
    vt[1]  = '{27'h6000000, 27'h4000000, 8'h7F, 1'b0, 1'b0, 32'h3F000000, 3'b000};
    vt[2]  = '{27'h5000000, 27'h5000000, 8'h00, 1'b0, 1'b0, 32'h00000000, 3'b010};
    vt[3]  = '{27'h4000004, 27'h0000000, 8'h7F, 1'b0, 1'b1, 32'h3F800000, 3'b001};
    vt[4]  = '{27'h400000C, 27'h0000000, 8'h7F, 1'b0, 1'b1, 32'h3F800002, 3'b001};
    vt[5]  = '{27'h7FFFFF8, 27'h7FFFFF8, 8'hFE, 1'b0, 1'b1, 32'h7F800000, 3'b100};
    vt[6]  = '{27'h2000000, 27'h2000000, 8'h00, 1'b0, 1'b1, 32'h00800000, 3'b000};
    vt[7]  = '{27'h6000000, 27'h4000000, 8'h7F, 1'b1, 1'b0, 32'hBF000000, 3'b000};
    vt[8]  = '{27'h5000000, 27'h5000000, 8'h00, 1'b1, 1'b0, 32'h80000000, 3'b010};
    vt[9]  = '{27'h4000000, 27'h4000000, 8'hFF, 1'b1, 1'b0, 32'hFF800000, 3'b000};
    vt[10] = '{27'h7FFFFFC, 27'h0000000, 8'h7F, 1'b0, 1'b1, 32'h40000000, 3'b001};
    vt[11] = '{27'h7FFFFFC, 27'h0000000, 8'hFE, 1'b0, 1'b1, 32'h7F800000, 3'b101};
    vt[12] = '{27'h0000010, 27'h0000008, 8'h00, 1'b0, 1'b0, 32'h00000001, 3'b000};
    vt[13] = '{27'h3FFFFFC, 27'h0000000, 8'h00, 1'b0, 1'b1, 32'h00800000, 3'b001};
    vt[14] = '{27'h4000001, 27'h4000000, 8'h7F, 1'b0, 1'b1, 32'h40000000, 3'b001};
    vt[15] = '{27'h4000000, 27'h3FFFFF8, 8'h7F, 1'b0, 1'b0, 32'h34000000, 3'b000};
  end

  task put(input int i, input bit push);
    fracta_in  = vt[i].a;
    fractb_in  = vt[i].b;
    exp_in     = vt[i].e;
    sign_in    = vt[i].s;
    fasu_op_in = vt[i].op;
    in_valid   = 1'b1;
    if (push) expq.push_back('{vt[i].res, vt[i].flg, cyc + 3});
  endtask

  task drive(input int i);
    @(negedge clk);
    put(i, 1'b1);
  endtask

  task idle;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task test_reset;
    rst_n = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid: got %b want 0", out_valid); end
    total++;
    if (result !== 32'h0) begin bad++; $display("[TB] FAIL reset_result: got %h want 00000000", result); end
    total++;
    if ({out_overflow, out_zero, out_inexact} !== 3'b000)
      begin bad++; $display("[TB] FAIL reset_flags: got %b want 000", {out_overflow, out_zero, out_inexact}); end
    put(0, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_hold_valid: got %b want 0", out_valid); end
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    total++;
    if (out_valid !== 1'b0 || obsq.size() != 0)
      begin bad++; $display("[TB] FAIL reset_release_idle: got valid=%b count=%0d want 0/0", out_valid, obsq.size()); end
    obsq.delete();
  endtask

  task test_arith;
    int   guard;
    rec_t e, o;
    drive(0); drive(1); drive(2); drive(7); drive(8); drive(9); drive(15); drive(14);
    idle;
    guard = 0;
    while (obsq.size() < expq.size() && guard < 20) begin @(posedge clk); guard++; end
    repeat (4) @(posedge clk);
    total++;
    if (obsq.size() != expq.size())
      begin bad++; $display("[TB] FAIL arith_count: got %0d results want %0d", obsq.size(), expq.size()); end
    while (expq.size() > 0 && obsq.size() > 0) begin
      e = expq.pop_front();
      o = obsq.pop_front();
      total++;
      if (o.res !== e.res) begin bad++; $display("[TB] FAIL arith_result: got %h want %h", o.res, e.res); end
      total++;
      if (o.flg !== e.flg) begin bad++; $display("[TB] FAIL arith_flags: got %b want %b (res %h)", o.flg, e.flg, e.res); end
      total++;
      if (o.cyc != e.cyc) begin bad++; $display("[TB] FAIL arith_latency: got cycle %0d want %0d", o.cyc, e.cyc); end
    end
    expq.delete();
    obsq.delete();
  endtask

  task test_round_and_limits;
    int   guard;
    rec_t e, o;
    drive(3); drive(4); drive(10); drive(11); drive(5); drive(6); drive(12); drive(13);
    idle;
    guard = 0;
    while (obsq.size() < expq.size() && guard < 20) begin @(posedge clk); guard++; end
    repeat (4) @(posedge clk);
    total++;
    if (obsq.size() != expq.size())
      begin bad++; $display("[TB] FAIL round_count: got %0d results want %0d", obsq.size(), expq.size()); end
    while (expq.size() > 0 && obsq.size() > 0) begin
      e = expq.pop_front();
      o = obsq.pop_front();
      total++;
      if (o.res !== e.res) begin bad++; $display("[TB] FAIL round_result: got %h want %h", o.res, e.res); end
      total++;
      if (o.flg !== e.flg) begin bad++; $display("[TB] FAIL round_flags: got %b want %b (res %h)", o.flg, e.flg, e.res); end
      total++;
      if (o.cyc != e.cyc) begin bad++; $display("[TB] FAIL round_latency: got cycle %0d want %0d", o.cyc, e.cyc); end
    end
    expq.delete();
    obsq.delete();
  endtask

  task test_back_to_back;
    int   guard;
    rec_t e, o;
    for (int k = 0; k < 3; k++) begin
      drive(0); drive(1); drive(2); drive(3); drive(4); drive(5);
    end
    idle;
    drive(6);
    idle;
    drive(1);
    idle;
    guard = 0;
    while (obsq.size() < expq.size() && guard < 40) begin @(posedge clk); guard++; end
    repeat (4) @(posedge clk);
    total++;
    if (obsq.size() != expq.size())
      begin bad++; $display("[TB] FAIL b2b_count: got %0d results want %0d", obsq.size(), expq.size()); end
    while (expq.size() > 0 && obsq.size() > 0) begin
      e = expq.pop_front();
      o = obsq.pop_front();
      total++;
      if (o.res !== e.res) begin bad++; $display("[TB] FAIL b2b_result: got %h want %h", o.res, e.res); end
      total++;
      if (o.flg !== e.flg) begin bad++; $display("[TB] FAIL b2b_flags: got %b want %b (res %h)", o.flg, e.flg, e.res); end
      total++;
      if (o.cyc != e.cyc) begin bad++; $display("[TB] FAIL b2b_latency: got cycle %0d want %0d", o.cyc, e.cyc); end
    end
    expq.delete();
    obsq.delete();
  endtask

  task test_reset_midstream;
    int   guard;
    rec_t e, o;
    drive(0); drive(1); drive(2); drive(3);
    @(posedge clk);
    #2;
    total++;
    if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL midreset_pre_valid: got %b want 1", out_valid); end
    rst_n = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL midreset_valid_drop: got %b want 0", out_valid); end
    total++;
    if (result !== 32'h0 || {out_overflow, out_zero, out_inexact} !== 3'b000)
      begin bad++; $display("[TB] FAIL midreset_clear: got %h/%b want 00000000/000", result, {out_overflow, out_zero, out_inexact}); end
    expq.delete();
    obsq.delete();
    put(4, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    expq.push_back('{vt[4].res, vt[4].flg, cyc + 3});
    drive(5); drive(0); drive(9);
    idle;
    guard = 0;
    while (obsq.size() < expq.size() && guard < 20) begin @(posedge clk); guard++; end
    repeat (4) @(posedge clk);
    total++;
    if (obsq.size() != expq.size())
      begin bad++; $display("[TB] FAIL midreset_count: got %0d results want %0d", obsq.size(), expq.size()); end
    while (expq.size() > 0 && obsq.size() > 0) begin
      e = expq.pop_front();
      o = obsq.pop_front();
      total++;
      if (o.res !== e.res) begin bad++; $display("[TB] FAIL midreset_result: got %h want %h", o.res, e.res); end
      total++;
      if (o.flg !== e.flg) begin bad++; $display("[TB] FAIL midreset_flags: got %b want %b (res %h)", o.flg, e.flg, e.res); end
      total++;
      if (o.cyc != e.cyc) begin bad++; $display("[TB] FAIL midreset_latency: got cycle %0d want %0d", o.cyc, e.cyc); end
    end
    expq.delete();
    obsq.delete();
  endtask

  initial begin
    rst_n      = 1'b1;
    in_valid   = 1'b0;
    fracta_in  = '0;
    fractb_in  = '0;
    exp_in     = '0;
    sign_in    = 1'b0;
    fasu_op_in = 1'b0;
    #2;
    test_reset;
    test_arith;
    test_round_and_limits;
    test_back_to_back;
    test_reset_midstream;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
